// File: rtl/frv_exec_buffer.sv
// -----------------------------------------------------------------------------
// frv_exec_buffer
//
// Execute-to-writeback pipeline buffer. Captures the ALU result, destination
// register and branch outcome of every accepted instruction and presents one
// registered, handshaked record to writeback. A two-entry skid buffer (head +
// skid) keeps s_ready a pure function of registered occupancy, so the upstream
// ready path never depends combinationally on m_ready.
//
// Parameters:
//   XLEN  datapath width
//   RD_W  destination register index width
//
// Ports:
//   g_clk, g_reset         clock, synchronous active-high reset
//   s_valid / s_ready      upstream handshake
//   s_flush                drop all held and incoming records
//   s_result, s_add_result ALU result and adder output (branch target)
//   s_lt, s_eq, s_br_op    branch condition flags and condition code
//   s_rd, s_wen            destination register and write enable
//   m_valid / m_ready      downstream handshake
//   m_result, m_rd, m_wen,
//   m_br_taken, m_br_target head record fields, forced to 0 when empty
//
// Optional feature (macro FRV_EXEC_BUFFER_PERF_EN):
//   perf_br_taken_cnt  popped records with branch taken
//   perf_stall_cnt     cycles with m_valid && !m_ready
//   Both wrap, clear on g_reset, and ignore s_flush.
// -----------------------------------------------------------------------------
module frv_exec_buffer #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_flush,
    input  logic [XLEN-1:0] s_result,
    input  logic [XLEN-1:0] s_add_result,
    input  logic            s_lt,
    input  logic            s_eq,
    input  logic [2:0]      s_br_op,
    input  logic [RD_W-1:0] s_rd,
    input  logic            s_wen,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [XLEN-1:0] m_result,
    output logic [RD_W-1:0] m_rd,
    output logic            m_wen,
    output logic            m_br_taken,
    output logic [XLEN-1:0] m_br_target
`ifdef FRV_EXEC_BUFFER_PERF_EN
    ,
    output logic [31:0]     perf_br_taken_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;
    localparam logic [2:0] BR_AL   = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] target;
        logic [RD_W-1:0] rd;
        logic            wen;
        logic            taken;
    } entry_t;

    // Occupancy is the buffer's only state machine: 0, 1 or 2 held records.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    function automatic logic br_resolve(input logic [2:0] op, input logic lt, input logic eq);
        logic taken;
        case (op)
            BR_NONE: taken = 1'b0;
            BR_EQ:   taken = eq;
            BR_NE:   taken = !eq;
            BR_LT:   taken = lt;
            BR_GE:   taken = !lt;
            BR_AL:   taken = 1'b1;
            default: taken = 1'b0;  // reserved codes behave as "no branch"
        endcase
        return taken;
    endfunction

    occ_t   occ_p1, occ_nxt;
    entry_t head_p1, skid_p1;
    entry_t cap_p0;
    logic   push, pop;
    logic   load_head, load_skid, shift_skid;

    // ---- stage p0: capture and branch resolution of the incoming record ----
    always_comb begin
        cap_p0.result = s_result;
        cap_p0.target = s_add_result;
        cap_p0.rd     = s_rd;
        cap_p0.wen    = s_wen;
        cap_p0.taken  = br_resolve(s_br_op, s_lt, s_eq);
    end

    assign s_ready = !g_reset && (occ_p1 != OCC_FULL);
    // Masking with reset keeps held entries from being presented while reset is asserted.
    assign m_valid = !g_reset && (occ_p1 != OCC_EMPTY);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_comb begin
        occ_nxt    = occ_p1;
        load_head  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        if (s_flush) begin
            // A same-cycle pop has already been seen on m_*; nothing else survives.
            occ_nxt = OCC_EMPTY;
        end else begin
            case (occ_p1)
                OCC_EMPTY: begin
                    if (push) begin
                        load_head = 1'b1;
                        occ_nxt   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        load_head = 1'b1;
                    end else if (push) begin
                        load_skid = 1'b1;
                        occ_nxt   = OCC_FULL;
                    end else if (pop) begin
                        occ_nxt = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // s_ready is low here, so only a pop can happen.
                    if (pop) begin
                        shift_skid = 1'b1;
                        occ_nxt    = OCC_ONE;
                    end
                end
                default: occ_nxt = OCC_EMPTY;
            endcase
        end
    end

    // ---- stage p1: registered head/skid entries and occupancy ----
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            occ_p1  <= OCC_EMPTY;
            head_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            occ_p1 <= occ_nxt;
            if (load_head) begin
                head_p1 <= cap_p0;
            end else if (shift_skid) begin
                head_p1 <= skid_p1;
            end
            if (load_skid) begin
                skid_p1 <= cap_p0;
            end
        end
    end

    assign m_result    = m_valid ? head_p1.result : '0;
    assign m_rd        = m_valid ? head_p1.rd     : '0;
    assign m_wen       = m_valid ? head_p1.wen    : 1'b0;
    assign m_br_taken  = m_valid ? head_p1.taken  : 1'b0;
    assign m_br_target = m_valid ? head_p1.target : '0;

`ifdef FRV_EXEC_BUFFER_PERF_EN
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            perf_br_taken_cnt <= '0;
            perf_stall_cnt    <= '0;
        end else begin
            if (pop && m_br_taken) begin
                perf_br_taken_cnt <= perf_br_taken_cnt + 32'd1;
            end
            if (m_valid && !m_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frv_exec_buffer.sv
// -----------------------------------------------------------------------------
// tb_frv_exec_buffer
//
// Scoreboard bench for frv_exec_buffer. The reference model is a bounded
// queue of expected records (capacity 2); accepted stimulus is pushed with its
// branch outcome computed from the condition-code rules, and the monitor
// compares every presented head record, the handshake signals and the empty
// masking against it.
// -----------------------------------------------------------------------------
module tb_frv_exec_buffer;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic            g_clk = 1'b0;
    logic            g_reset;
    logic            s_valid;
    logic            s_ready;
    logic            s_flush;
    logic [XLEN-1:0] s_result;
    logic [XLEN-1:0] s_add_result;
    logic            s_lt;
    logic            s_eq;
    logic [2:0]      s_br_op;
    logic [RD_W-1:0] s_rd;
    logic            s_wen;
    logic            m_valid;
    logic            m_ready;
    logic [XLEN-1:0] m_result;
    logic [RD_W-1:0] m_rd;
    logic            m_wen;
    logic            m_br_taken;
    logic [XLEN-1:0] m_br_target;
`ifdef FRV_EXEC_BUFFER_PERF_EN
    logic [31:0]     perf_br_taken_cnt;
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     mdl_br_cnt;
    logic [31:0]     mdl_stall_cnt;
`endif

    always #5 g_clk = ~g_clk;

    frv_exec_buffer #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .g_clk        (g_clk),
        .g_reset      (g_reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_flush      (s_flush),
        .s_result     (s_result),
        .s_add_result (s_add_result),
        .s_lt         (s_lt),
        .s_eq         (s_eq),
        .s_br_op      (s_br_op),
        .s_rd         (s_rd),
        .s_wen        (s_wen),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_result     (m_result),
        .m_rd         (m_rd),
        .m_wen        (m_wen),
        .m_br_taken   (m_br_taken),
        .m_br_target  (m_br_target)
`ifdef FRV_EXEC_BUFFER_PERF_EN
        ,
        .perf_br_taken_cnt (perf_br_taken_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] result;
        logic [31:0] target;
        logic [4:0]  rd;
        logic        wen;
        logic        taken;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic ref_taken(input int op, input logic lt, input logic eq);
        if (op == 1) return eq;
        if (op == 2) return !eq;
        if (op == 3) return lt;
        if (op == 4) return !lt;
        if (op == 5) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor + reference model, sampled on the falling edge when all inputs
    // and registered outputs are stable.
    always @(negedge g_clk) begin
        logic exp_rdy, exp_mv;
        rec_t r;
        exp_rdy = !g_reset && (exp_q.size() < 2);
        exp_mv  = !g_reset && (exp_q.size() != 0);
        chk("s_ready", {31'd0, s_ready}, {31'd0, exp_rdy});
        chk("m_valid", {31'd0, m_valid}, {31'd0, exp_mv});
        if (exp_mv) begin
            chk("m_result",    m_result,            exp_q[0].result);
            chk("m_rd",        {27'd0, m_rd},       {27'd0, exp_q[0].rd});
            chk("m_wen",       {31'd0, m_wen},      {31'd0, exp_q[0].wen});
            chk("m_br_taken",  {31'd0, m_br_taken}, {31'd0, exp_q[0].taken});
            chk("m_br_target", m_br_target,         exp_q[0].target);
        end else begin
            chk("empty_result", m_result, 32'd0);
            chk("empty_fields", {26'd0, m_rd, m_wen, m_br_taken}, 32'd0);
            chk("empty_target", m_br_target, 32'd0);
        end
`ifdef FRV_EXEC_BUFFER_PERF_EN
        chk("perf_br_taken_cnt", perf_br_taken_cnt, mdl_br_cnt);
        chk("perf_stall_cnt",    perf_stall_cnt,    mdl_stall_cnt);
        if (g_reset) begin
            mdl_br_cnt    = 32'd0;
            mdl_stall_cnt = 32'd0;
        end else begin
            if (exp_mv && m_ready && exp_q[0].taken) mdl_br_cnt = mdl_br_cnt + 32'd1;
            if (exp_mv && !m_ready) mdl_stall_cnt = mdl_stall_cnt + 32'd1;
        end
`endif
        if (g_reset || s_flush) begin
            exp_q.delete();
        end else begin
            if (exp_mv && m_ready) void'(exp_q.pop_front());
            if (exp_rdy && s_valid) begin
                r.result = s_result;
                r.target = s_add_result;
                r.rd     = s_rd;
                r.wen    = s_wen;
                r.taken  = ref_taken(int'(s_br_op), s_lt, s_eq);
                exp_q.push_back(r);
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] res, input logic [31:0] tgt,
                        input logic lt, input logic eq, input logic [2:0] op,
                        input logic [4:0] rd, input logic wen,
                        input logic mr, input logic fl, input logic rst);
        @(posedge g_clk);
        #1;
        s_valid      = v;
        s_result     = res;
        s_add_result = tgt;
        s_lt         = lt;
        s_eq         = eq;
        s_br_op      = op;
        s_rd         = rd;
        s_wen        = wen;
        m_ready      = mr;
        s_flush      = fl;
        g_reset      = rst;
    endtask

    task automatic idle(input logic mr);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, mr, 1'b0, 1'b0);
    endtask

    task automatic push_val(input logic [31:0] res, input logic mr);
        step(1'b1, res, res + 32'h100, 1'b0, 1'b0, 3'd0, res[4:0], 1'b1, mr, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] ops [5];
        logic       lts [5];
        logic       eqs [5];
`ifdef FRV_EXEC_BUFFER_PERF_EN
        mdl_br_cnt    = 32'd0;
        mdl_stall_cnt = 32'd0;
`endif
        g_reset = 1'b1; s_valid = 1'b0; s_flush = 1'b0; s_result = '0; s_add_result = '0;
        s_lt = 1'b0; s_eq = 1'b0; s_br_op = '0; s_rd = '0; s_wen = 1'b0; m_ready = 1'b0;

        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Single push then drain.
        step(1'b1, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Branch resolution cases, one per cycle, fixed target.
        ops = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        lts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        eqs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h10 + i, 32'h8000_0010, lts[i], eqs[i], ops[i], 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h20, 32'h8000_0010, 1'b0, 1'b0, 3'd5, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: A, B, C with m_ready low; C must be refused.
        push_val(32'hA, 1'b0);
        push_val(32'hB, 1'b0);
        push_val(32'hC, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Streaming 1..8.
        for (int i = 1; i <= 8; i++) push_val(i, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while full with a concurrent push.
        push_val(32'h51, 1'b0);
        push_val(32'h52, 1'b0);
        step(1'b1, 32'h53, 32'h153, 1'b0, 1'b0, 3'd5, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Reset while full, then a fresh push.
        push_val(32'h61, 1'b0);
        push_val(32'h62, 1'b0);
        step(1'b1, 32'h63, 32'h163, 1'b0, 1'b1, 3'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        push_val(32'h64, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            step(1'b1 & ($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        @(posedge g_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frv_exec_buffer.md
Name: frv_exec_buffer

Overview:
- Execute-to-writeback pipeline buffer. Sits directly downstream of the execute-stage ALU.
- Captures the ALU result, destination register and branch condition outputs (lt/eq/add result) each cycle an instruction is accepted.
- Resolves branch-taken from a condition code and presents one registered, handshaked record to writeback.
- Two-entry skid buffer, so the upstream ready never depends combinationally on downstream ready.

Parameters:
- XLEN, 32, datapath width.
- RD_W, 5, destination register index width.

Ports:
- g_clk  in  1  global clock
- g_reset  in  1  reset: one clock; reset is synchronous and active-high
- s_valid  in  1  upstream record valid
- s_ready  out  1  buffer can accept a record
- s_flush  in  1  discard all held and incoming records
- s_result  in  XLEN  ALU result
- s_add_result  in  XLEN  adder output, used as branch target
- s_lt  in  1  ALU less-than flag
- s_eq  in  1  ALU equal flag
- s_br_op  in  3  condition: 0 none, 1 EQ, 2 NE, 3 LT, 4 GE, 5 always; 6-7 treated as none
- s_rd  in  RD_W  destination register
- s_wen  in  1  register write enable
- m_valid  out  1  head record valid
- m_ready  in  1  writeback accepts head
- m_result  out  XLEN  head result
- m_rd  out  RD_W  head destination
- m_wen  out  1  head write enable
- m_br_taken  out  1  head branch taken
- m_br_target  out  XLEN  head branch target

Behaviour:
- Storage: two entries (head, skid) plus a 2-bit occupancy count, 0..2.
- Push = s_valid && s_ready. Pop = m_valid && m_ready.
- s_ready = !g_reset && count < 2, decoded from registered count only.
- m_valid = count != 0.
- Branch resolution happens at capture and is registered with the entry:
  - taken = (op==1 && eq) || (op==2 && !eq) || (op==3 && lt) || (op==4 && !lt) || op==5.
  - s_add_result is stored as the target regardless of taken.
- Latency: a record pushed in cycle N appears on m_* in cycle N+1 if the buffer was empty. Throughput is 1 record/cycle with m_ready held high.
- Ordering is strict FIFO.
  - count 1, push and pop together: count stays 1 and the pushed record becomes head.
  - count 2, pop: skid moves to head and count becomes 1. No push is possible that cycle.
- Empty (count 0): m_result, m_rd, m_wen, m_br_taken and m_br_target are driven 0. Pop is ignored.
- Full (count 2): s_ready = 0 and any s_valid is ignored.
- Flush (s_flush=1): next cycle count = 0.
  - Any same-cycle push is discarded.
  - A same-cycle pop still completes on m_* but has no further effect.
  - Flush has priority over push and pop.
- Reset: count=0, all entry fields=0, m_valid=0, s_ready=0 during reset, s_ready=1 the first cycle after.
- Reset asserted mid-operation: held entries are lost without being presented. Behaviour matches power-on reset.
- Entry storage needs no enable beyond push/shift; holding values while invalid is permitted, but outputs are masked to 0 when empty.

Optional Feature:
- Macro: FRV_EXEC_BUFFER_PERF_EN.
- When defined, adds outputs perf_br_taken_cnt (32) and perf_stall_cnt (32).
  - perf_br_taken_cnt increments on each pop whose m_br_taken=1.
  - perf_stall_cnt increments each cycle with m_valid && !m_ready.
  - Both wrap 0xFFFFFFFF -> 0, clear on g_reset, and are unaffected by s_flush.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then single push of result=0x0000_1234, rd=5, wen=1, br_op=0, m_ready=1 -> m_valid=1 next cycle with m_result=0x1234, m_rd=5, m_br_taken=0; m_valid=0 the cycle after.
- Branch resolve, sequential pushes:
  - br_op=1, eq=1 -> taken=1.
  - br_op=2, eq=1 -> taken=0.
  - br_op=3, lt=1 -> taken=1.
  - br_op=4, lt=1 -> taken=0.
  - br_op=7 -> taken=0.
  - Target 0x8000_0010 appears on m_br_target in every case.
- Backpressure: m_ready=0, push A, B, C each cycle -> s_ready drops after B, C is not accepted. Raise m_ready -> A then B delivered in order, s_ready returns 1 after the first pop.
- Streaming: s_valid=1 and m_ready=1 for 8 cycles with results 1..8 -> outputs 1..8 on consecutive cycles, count never exceeds 1.
- Flush with count=2 and concurrent s_valid=1 -> next cycle m_valid=0, count=0, and the flushed-cycle input never appears.
- Reset mid-stream with count=2 -> m_valid=0 and s_ready=0 during reset; after release, perf counters (if enabled) read 0 and a new push delivers normally.
